regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_wb_arbiter_if.sv | 51 +++++
 rtl/rr_arb2.sv | 36 +++
 rtl/regfile_wb_arbiter.sv | 78 +++++++
 tb/tb_regfile_wb_arbiter.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and grant encoding for the register-file write-back arbiter.
package regfile_pkg;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned ADDR_W = 5;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back request/grant bus between the two requesters and the arbiter.
// REGFILE_WB_BYPASS_EN adds the read-address / read-data bypass signals.
interface regfile_wb_arbiter_if #(
  parameter int unsigned CNT_W = 16
);
  import regfile_pkg::*;

  logic              hold;
  logic              a_valid;
  logic [ADDR_W-1:0] a_addr;
  logic [WIDTH-1:0]  a_data;
  logic              a_ready;
  logic              b_valid;
  logic [ADDR_W-1:0] b_addr;
  logic [WIDTH-1:0]  b_data;
  logic              b_ready;
  logic              we3;
  logic [ADDR_W-1:0] wa3;
  logic [WIDTH-1:0]  wd3;
  logic [CNT_W-1:0]  conflict_cnt;

`ifdef REGFILE_WB_BYPASS_EN
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [WIDTH-1:0]  rf_rd1;
  logic [WIDTH-1:0]  rf_rd2;
  logic [WIDTH-1:0]  rd1;
  logic [WIDTH-1:0]  rd2;

  modport slave (
    input  hold, a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  ra1, ra2, rf_rd1, rf_rd2,
    output a_ready, b_ready, we3, wa3, wd3, conflict_cnt, rd1, rd2
  );
  modport master (
    output hold, a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output ra1, ra2, rf_rd1, rf_rd2,
    input  a_ready, b_ready, we3, wa3, wd3, conflict_cnt, rd1, rd2
  );
`else
  modport slave (
    input  hold, a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready, we3, wa3, wd3, conflict_cnt
  );
  modport master (
    output hold, a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready, we3, wa3, wd3, conflict_cnt
  );
`endif

endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; owns the last_grant flop.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       hold,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  grant_t last_grant_q;
  grant_t last_grant_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_grant_q <= GRANT_B;
    else       last_grant_q <= last_grant_d;
  end

  // On a tie the port that did not win last time is granted.
  always_comb begin
    gnt          = 2'b00;
    last_grant_d = last_grant_q;
    if (!hold) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_grant_q == GRANT_B) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
    if (gnt[0])      last_grant_d = GRANT_A;
    else if (gnt[1]) last_grant_d = GRANT_B;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between ALU (A) and load (B) write-back.
// Optional read bypass of the registered write enabled by REGFILE_WB_BYPASS_EN.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  bus
);

  logic [1:0]        gnt;
  logic              xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [WIDTH-1:0]  sel_data;
  logic              conflict;

  logic              we3_q, we3_d;
  logic [ADDR_W-1:0] wa3_q, wa3_d;
  logic [WIDTH-1:0]  wd3_q, wd3_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .hold  (bus.hold),
    .req   ({bus.b_valid, bus.a_valid}),
    .gnt   (gnt)
  );

  assign bus.a_ready = gnt[0];
  assign bus.b_ready = gnt[1];

  assign xfer     = |gnt;
  assign sel_addr = gnt[1] ? bus.b_addr : bus.a_addr;
  assign sel_data = gnt[1] ? bus.b_data : bus.a_data;
  assign conflict = bus.a_valid & bus.b_valid & ~bus.hold;

  // x0 writes complete the handshake but never reach the register file.
  always_comb begin
    we3_d = 1'b0;
    wa3_d = wa3_q;
    wd3_d = wd3_q;
    cnt_d = cnt_q;
    if (xfer) begin
      we3_d = (sel_addr != '0);
      wa3_d = sel_addr;
      wd3_d = sel_data;
    end
    if (conflict && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we3_q <= 1'b0;
      wa3_q <= '0;
      wd3_q <= '0;
      cnt_q <= '0;
    end else begin
      we3_q <= we3_d;
      wa3_q <= wa3_d;
      wd3_q <= wd3_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.we3          = we3_q;
  assign bus.wa3          = wa3_q;
  assign bus.wd3          = wd3_q;
  assign bus.conflict_cnt = cnt_q;

`ifdef REGFILE_WB_BYPASS_EN
  assign bus.rd1 = (we3_q && (wa3_q == bus.ra1) && (bus.ra1 != '0)) ? wd3_q : bus.rf_rd1;
  assign bus.rd2 = (we3_q && (wa3_q == bus.ra2) && (bus.ra2 != '0)) ? wd3_q : bus.rf_rd2;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (CNT_W=4 to reach saturation).
module tb_regfile_wb_arbiter;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  regfile_wb_arbiter_if #(.CNT_W(4)) bus ();

  regfile_wb_arbiter #(.CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    bus.hold    = 1'b0;
    bus.a_valid = 1'b0;
    bus.a_addr  = '0;
    bus.a_data  = '0;
    bus.b_valid = 1'b0;
    bus.b_addr  = '0;
    bus.b_data  = '0;
`ifdef REGFILE_WB_BYPASS_EN
    bus.ra1     = '0;
    bus.ra2     = '0;
    bus.rf_rd1  = '0;
    bus.rf_rd2  = '0;
`endif
    repeat (2) tick();
    chk("rst_we3", 64'(bus.we3), 64'd0);
    chk("rst_wa3", 64'(bus.wa3), 64'd0);
    chk("rst_wd3", 64'(bus.wd3), 64'd0);
    chk("rst_cnt", 64'(bus.conflict_cnt), 64'd0);
    reset = 1'b0;

    // Single A request
    bus.a_valid = 1'b1; bus.a_addr = 5'd5; bus.a_data = 32'hDEADBEEF;
    #1;
    chk("t1_a_ready", 64'(bus.a_ready), 64'd1);
    chk("t1_b_ready", 64'(bus.b_ready), 64'd0);
    tick();
    bus.a_valid = 1'b0;
    chk("t1_we3", 64'(bus.we3), 64'd1);
    chk("t1_wa3", 64'(bus.wa3), 64'd5);
    chk("t1_wd3", 64'(bus.wd3), 64'hDEADBEEF);
    tick();
    chk("t1_idle_we3", 64'(bus.we3), 64'd0);
    chk("t1_idle_wa3", 64'(bus.wa3), 64'd5);

    // Continuous conflict from reset: A,B,A,B
    do_reset();
    bus.a_valid = 1'b1; bus.a_addr = 5'd1; bus.a_data = 32'h11;
    bus.b_valid = 1'b1; bus.b_addr = 5'd2; bus.b_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_a_ready", 64'(bus.a_ready), (i % 2 == 0) ? 64'd1 : 64'd0);
      chk("t2_b_ready", 64'(bus.b_ready), (i % 2 == 0) ? 64'd0 : 64'd1);
      tick();
      chk("t2_we3", 64'(bus.we3), 64'd1);
      chk("t2_wa3", 64'(bus.wa3), (i % 2 == 0) ? 64'd1 : 64'd2);
      chk("t2_wd3", 64'(bus.wd3), (i % 2 == 0) ? 64'h11 : 64'h22);
    end
    chk("t2_cnt", 64'(bus.conflict_cnt), 64'd4);
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    tick();
    chk("t2_idle_we3", 64'(bus.we3), 64'd0);
    chk("t2_idle_wa3", 64'(bus.wa3), 64'd2);
    chk("t2_idle_cnt", 64'(bus.conflict_cnt), 64'd4);

    // x0 write: handshake completes, no write enable, updates last_grant to A
    bus.a_valid = 1'b1; bus.a_addr = 5'd0; bus.a_data = 32'h1234;
    #1;
    chk("t3_a_ready", 64'(bus.a_ready), 64'd1);
    tick();
    bus.a_valid = 1'b0;
    chk("t3_we3", 64'(bus.we3), 64'd0);
    chk("t3_wa3", 64'(bus.wa3), 64'd0);
    chk("t3_wd3", 64'(bus.wd3), 64'h1234);
    bus.a_valid = 1'b1; bus.a_addr = 5'd3; bus.a_data = 32'h33;
    bus.b_valid = 1'b1; bus.b_addr = 5'd4; bus.b_data = 32'h44;
    #1;
    chk("t3_conf_a_ready", 64'(bus.a_ready), 64'd0);
    chk("t3_conf_b_ready", 64'(bus.b_ready), 64'd1);
    tick();
    chk("t3_conf_we3", 64'(bus.we3), 64'd1);
    chk("t3_conf_wa3", 64'(bus.wa3), 64'd4);
    chk("t3_conf_cnt", 64'(bus.conflict_cnt), 64'd5);
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;

    // Hold suppresses grants and counting
    do_reset();
    bus.a_valid = 1'b1; bus.a_addr = 5'd1; bus.a_data = 32'h11;
    bus.b_valid = 1'b1; bus.b_addr = 5'd2; bus.b_data = 32'h22;
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_hold_a_ready", 64'(bus.a_ready), 64'd0);
      chk("t4_hold_b_ready", 64'(bus.b_ready), 64'd0);
      tick();
      chk("t4_hold_we3", 64'(bus.we3), 64'd0);
      chk("t4_hold_cnt", 64'(bus.conflict_cnt), 64'd0);
    end
    bus.hold = 1'b0;
    #1;
    chk("t4_rel_a_ready", 64'(bus.a_ready), 64'd1);
    tick();
    chk("t4_rel_wa3", 64'(bus.wa3), 64'd1);
    chk("t4_rel_cnt", 64'(bus.conflict_cnt), 64'd1);

    // Saturation of the 4-bit counter
    repeat (14) tick();
    chk("t5_cnt_full", 64'(bus.conflict_cnt), 64'hF);
    repeat (3) tick();
    chk("t5_cnt_sat", 64'(bus.conflict_cnt), 64'hF);

    // Async reset while B is transferring
    chk("t6_a_turn", 64'(bus.a_ready), 64'd1);
    tick();
    chk("t6_b_turn", 64'(bus.b_ready), 64'd1);
    chk("t6_pre_we3", 64'(bus.we3), 64'd1);
    reset = 1'b1;
    #1;
    chk("t6_async_we3", 64'(bus.we3), 64'd0);
    chk("t6_async_cnt", 64'(bus.conflict_cnt), 64'd0);
    tick();
    chk("t6_drop_we3", 64'(bus.we3), 64'd0);
    reset = 1'b0;
    #1;
    chk("t6_post_a_ready", 64'(bus.a_ready), 64'd1);
    tick();
    chk("t6_post_we3", 64'(bus.we3), 64'd1);
    chk("t6_post_wa3", 64'(bus.wa3), 64'd1);
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    tick();

`ifdef REGFILE_WB_BYPASS_EN
    bus.a_valid = 1'b1; bus.a_addr = 5'd7; bus.a_data = 32'hCAFEF00D;
    tick();
    bus.a_valid = 1'b0;
    bus.ra1 = 5'd7; bus.rf_rd1 = 32'h111;
    #1;
    chk("byp_rd1_fwd", 64'(bus.rd1), 64'hCAFEF00D);
    bus.a_valid = 1'b1; bus.a_addr = 5'd0; bus.a_data = 32'h55;
    tick();
    bus.a_valid = 1'b0;
    bus.ra2 = 5'd0; bus.rf_rd2 = 32'h222;
    #1;
    chk("byp_rd2_x0", 64'(bus.rd2), 64'h222);
    chk("byp_rd1_rf", 64'(bus.rd1), 64'h111);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
